// File: rtl/ariane_ace.sv
// Shared ACE snoop-channel field widths and encodings for the Ariane cache subsystem.
package ariane_ace;

  localparam int unsigned AcSnoopWidth = 4;
  localparam int unsigned AcProtWidth  = 3;
  localparam int unsigned CrRespWidth  = 5;

  // CR response bit positions
  localparam int unsigned CrRespDataTransfer = 0;
  localparam int unsigned CrRespError        = 1;
  localparam int unsigned CrRespPassDirty    = 2;
  localparam int unsigned CrRespIsShared     = 3;
  localparam int unsigned CrRespWasUnique    = 4;

  typedef enum logic [AcSnoopWidth-1:0] {
    AcReadOnce           = 4'b0000,
    AcReadShared         = 4'b0001,
    AcReadClean          = 4'b0010,
    AcReadNotSharedDirty = 4'b0011,
    AcReadUnique         = 4'b0111,
    AcCleanShared        = 4'b1000,
    AcCleanInvalid       = 4'b1001,
    AcMakeInvalid        = 4'b1101,
    AcDvmComplete        = 4'b1110,
    AcDvmMessage         = 4'b1111
  } ac_snoop_e;

  typedef logic [CrRespWidth-1:0] cr_resp_t;

endpackage

// File: rtl/fifo_v3.sv
// Registered (non fall-through) FIFO, common_cells-compatible subset; flush_i clears synchronously.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned AddrDepth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AddrDepth-1:0] LastPtr = AddrDepth'(DEPTH - 1);
  localparam logic [AddrDepth:0]   FullCnt = (AddrDepth + 1)'(DEPTH);

  logic [AddrDepth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AddrDepth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrDepth:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + AddrDepth'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + AddrDepth'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + (AddrDepth + 1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (AddrDepth + 1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ace_snoop_buffer.sv
// Snoop buffer between the ACE interconnect and the dcache snoop port: queues AC,
// limits outstanding snoops, registers CR and gates/frames CD data.
module ace_snoop_buffer
  import ariane_ace::*;
#(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned AcDepth        = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned BeatsPerLine   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    ic_ac_valid_i,
  output logic                    ic_ac_ready_o,
  input  logic [AddrWidth-1:0]    ic_ac_addr_i,
  input  logic [AcSnoopWidth-1:0] ic_ac_snoop_i,
  input  logic [AcProtWidth-1:0]  ic_ac_prot_i,

  output logic                    dc_ac_valid_o,
  input  logic                    dc_ac_ready_i,
  output logic [AddrWidth-1:0]    dc_ac_addr_o,
  output logic [AcSnoopWidth-1:0] dc_ac_snoop_o,
  output logic [AcProtWidth-1:0]  dc_ac_prot_o,

  input  logic                    dc_cr_valid_i,
  output logic                    dc_cr_ready_o,
  input  logic [CrRespWidth-1:0]  dc_cr_resp_i,
  output logic                    ic_cr_valid_o,
  input  logic                    ic_cr_ready_i,
  output logic [CrRespWidth-1:0]  ic_cr_resp_o,

  input  logic                    dc_cd_valid_i,
  output logic                    dc_cd_ready_o,
  input  logic [DataWidth-1:0]    dc_cd_data_i,
  input  logic                    dc_cd_last_i,
  output logic                    ic_cd_valid_o,
  input  logic                    ic_cd_ready_i,
  output logic [DataWidth-1:0]    ic_cd_data_o,
  output logic                    ic_cd_last_o,

  output logic                    busy_o,
  output logic                    cd_err_o
);

  localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeatWidth = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1;
  localparam int unsigned AcWidth   = AddrWidth + AcSnoopWidth + AcProtWidth;
  localparam logic [CntWidth-1:0]  MaxOs    = CntWidth'(MaxOutstanding);
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(BeatsPerLine - 1);

  typedef enum logic {CdIdle, CdData} cd_state_e;

  logic [AcWidth-1:0]     ac_wdata, ac_rdata;
  logic                   ac_full, ac_empty;
  logic                   ac_push, ac_pop;
  logic                   dc_cr_hs, ic_cr_hs, cd_hs, has_data;

  logic [CntWidth-1:0]    outstanding_q, outstanding_d;
  logic [CntWidth-1:0]    data_pending_q, data_pending_d;
  logic                   cr_full_q, cr_full_d;
  logic [CrRespWidth-1:0] cr_resp_q, cr_resp_d;
  cd_state_e              cd_state_q, cd_state_d;
  logic [BeatWidth-1:0]   beat_q, beat_d;
  logic                   cd_err_q, cd_err_d;

  assign ac_wdata = {ic_ac_prot_i, ic_ac_snoop_i, ic_ac_addr_i};
  assign {dc_ac_prot_o, dc_ac_snoop_o, dc_ac_addr_o} = ac_rdata;

  fifo_v3 #(
    .DATA_WIDTH (AcWidth),
    .DEPTH      (AcDepth)
  ) i_ac_fifo (
    .clk_i   (clk_i),
    .rst_ni  (1'b1),
    .flush_i (rst_i),
    .full_o  (ac_full),
    .empty_o (ac_empty),
    .data_i  (ac_wdata),
    .push_i  (ac_push),
    .data_o  (ac_rdata),
    .pop_i   (ac_pop)
  );

  assign ic_ac_ready_o = ~ac_full;
  assign dc_ac_valid_o = ~ac_empty & (outstanding_q < MaxOs);
  assign ac_push       = ic_ac_valid_i & ic_ac_ready_o;
  assign ac_pop        = dc_ac_valid_o & dc_ac_ready_i;

  assign dc_cr_ready_o = ~cr_full_q | ic_cr_ready_i;
  assign ic_cr_valid_o = cr_full_q;
  assign ic_cr_resp_o  = cr_resp_q;
  assign dc_cr_hs      = dc_cr_valid_i & dc_cr_ready_o;
  assign ic_cr_hs      = cr_full_q & ic_cr_ready_i;

  assign has_data      = (data_pending_q != '0);
  assign ic_cd_valid_o = dc_cd_valid_i & has_data;
  assign dc_cd_ready_o = ic_cd_ready_i & has_data;
  assign ic_cd_data_o  = dc_cd_data_i;
  assign ic_cd_last_o  = dc_cd_last_i;
  assign cd_hs         = dc_cd_valid_i & ic_cd_ready_i & has_data;

  assign busy_o   = ~ac_empty | (outstanding_q != '0) | cr_full_q | has_data;
  assign cd_err_o = cd_err_q;

  always_comb begin
    outstanding_d = outstanding_q;
    if (ac_pop && !ic_cr_hs)      outstanding_d = outstanding_q + CntWidth'(1);
    else if (!ac_pop && ic_cr_hs) outstanding_d = outstanding_q - CntWidth'(1);

    // Draining and refilling the CR slot in the same cycle keeps it full.
    cr_full_d = cr_full_q;
    cr_resp_d = cr_resp_q;
    if (ic_cr_hs) cr_full_d = 1'b0;
    if (dc_cr_hs) begin
      cr_full_d = 1'b1;
      cr_resp_d = dc_cr_resp_i;
    end

    data_pending_d = data_pending_q;
    if ((ic_cr_hs && cr_resp_q[CrRespDataTransfer]) && !(cd_hs && dc_cd_last_i))
      data_pending_d = data_pending_q + CntWidth'(1);
    else if (!(ic_cr_hs && cr_resp_q[CrRespDataTransfer]) && (cd_hs && dc_cd_last_i))
      data_pending_d = data_pending_q - CntWidth'(1);
  end

  always_comb begin
    cd_state_d = cd_state_q;
    beat_d     = beat_q;
    cd_err_d   = cd_err_q;
    if (cd_hs) begin
      if (dc_cd_last_i != (beat_q == LastBeat)) cd_err_d = 1'b1;
      // A missing last on the final beat still restarts the index for the next line.
      if (dc_cd_last_i || (beat_q == LastBeat)) beat_d = '0;
      else                                      beat_d = beat_q + BeatWidth'(1);
      unique case (cd_state_q)
        CdIdle:  if (!dc_cd_last_i) cd_state_d = CdData;
        CdData:  if (dc_cd_last_i)  cd_state_d = CdIdle;
        default: cd_state_d = CdIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q  <= '0;
      data_pending_q <= '0;
      cr_full_q      <= 1'b0;
      cr_resp_q      <= '0;
      cd_state_q     <= CdIdle;
      beat_q         <= '0;
      cd_err_q       <= 1'b0;
    end else begin
      outstanding_q  <= outstanding_d;
      data_pending_q <= data_pending_d;
      cr_full_q      <= cr_full_d;
      cr_resp_q      <= cr_resp_d;
      cd_state_q     <= cd_state_d;
      beat_q         <= beat_d;
      cd_err_q       <= cd_err_d;
    end
  end

endmodule

// File: tb/tb_ace_snoop_buffer.sv
// Randomized and directed bench for ace_snoop_buffer against a queue-based reference model.
module tb_ace_snoop_buffer;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int Depth = 4;
  localparam int MaxOs = 4;
  localparam int Bpl = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ic_ac_valid_i, ic_ac_ready_o;
  logic [AW-1:0] ic_ac_addr_i;
  logic [3:0]    ic_ac_snoop_i;
  logic [2:0]    ic_ac_prot_i;
  logic          dc_ac_valid_o, dc_ac_ready_i;
  logic [AW-1:0] dc_ac_addr_o;
  logic [3:0]    dc_ac_snoop_o;
  logic [2:0]    dc_ac_prot_o;
  logic          dc_cr_valid_i, dc_cr_ready_o;
  logic [4:0]    dc_cr_resp_i;
  logic          ic_cr_valid_o, ic_cr_ready_i;
  logic [4:0]    ic_cr_resp_o;
  logic          dc_cd_valid_i, dc_cd_ready_o;
  logic [DW-1:0] dc_cd_data_i;
  logic          dc_cd_last_i;
  logic          ic_cd_valid_o, ic_cd_ready_i;
  logic [DW-1:0] ic_cd_data_o;
  logic          ic_cd_last_o;
  logic          busy_o, cd_err_o;

  always #5 clk_i = ~clk_i;

  ace_snoop_buffer #(
    .AddrWidth      (AW),
    .DataWidth      (DW),
    .AcDepth        (Depth),
    .MaxOutstanding (MaxOs),
    .BeatsPerLine   (Bpl)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ic_ac_valid_i (ic_ac_valid_i),
    .ic_ac_ready_o (ic_ac_ready_o),
    .ic_ac_addr_i  (ic_ac_addr_i),
    .ic_ac_snoop_i (ic_ac_snoop_i),
    .ic_ac_prot_i  (ic_ac_prot_i),
    .dc_ac_valid_o (dc_ac_valid_o),
    .dc_ac_ready_i (dc_ac_ready_i),
    .dc_ac_addr_o  (dc_ac_addr_o),
    .dc_ac_snoop_o (dc_ac_snoop_o),
    .dc_ac_prot_o  (dc_ac_prot_o),
    .dc_cr_valid_i (dc_cr_valid_i),
    .dc_cr_ready_o (dc_cr_ready_o),
    .dc_cr_resp_i  (dc_cr_resp_i),
    .ic_cr_valid_o (ic_cr_valid_o),
    .ic_cr_ready_i (ic_cr_ready_i),
    .ic_cr_resp_o  (ic_cr_resp_o),
    .dc_cd_valid_i (dc_cd_valid_i),
    .dc_cd_ready_o (dc_cd_ready_o),
    .dc_cd_data_i  (dc_cd_data_i),
    .dc_cd_last_i  (dc_cd_last_i),
    .ic_cd_valid_o (ic_cd_valid_o),
    .ic_cd_ready_i (ic_cd_ready_i),
    .ic_cd_data_o  (ic_cd_data_o),
    .ic_cd_last_o  (ic_cd_last_o),
    .busy_o        (busy_o),
    .cd_err_o      (cd_err_o)
  );

  typedef struct packed {
    logic [2:0]    prot;
    logic [3:0]    snoop;
    logic [AW-1:0] addr;
  } ac_t;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Reference model state
  ac_t        m_acq[$];
  logic [4:0] m_cr[$];
  int         m_os, m_dp, m_beat;
  logic       m_err;
  // Bench-side dcache state
  int         dc_pend, owed, src_beat, ac_hs_cnt;
  logic [DW-1:0] src_data;
  bit         f_ac_in, f_dc_ac, f_dc_cr, f_ic_cr, f_cd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_acq.delete();
    m_cr.delete();
    m_os = 0; m_dp = 0; m_beat = 0; m_err = 1'b0;
    dc_pend = 0; owed = 0; src_beat = 0; ac_hs_cnt = 0;
    f_ac_in = 0; f_dc_ac = 0; f_dc_cr = 0; f_ic_cr = 0; f_cd = 0;
  endtask

  task automatic check_outputs();
    bit exp_dcv = (m_acq.size() > 0) && (m_os < MaxOs);
    bit exp_crv = (m_cr.size() == 1);
    bit exp_cdv = dc_cd_valid_i && (m_dp != 0);
    check_eq("ic_ac_ready", 64'(ic_ac_ready_o), 64'(m_acq.size() < Depth));
    check_eq("dc_ac_valid", 64'(dc_ac_valid_o), 64'(exp_dcv));
    if (exp_dcv) begin
      check_eq("dc_ac_addr", dc_ac_addr_o, m_acq[0].addr);
      check_eq("dc_ac_snoop", 64'(dc_ac_snoop_o), 64'(m_acq[0].snoop));
      check_eq("dc_ac_prot", 64'(dc_ac_prot_o), 64'(m_acq[0].prot));
    end
    check_eq("ic_cr_valid", 64'(ic_cr_valid_o), 64'(exp_crv));
    if (exp_crv) check_eq("ic_cr_resp", 64'(ic_cr_resp_o), 64'(m_cr[0]));
    check_eq("dc_cr_ready", 64'(dc_cr_ready_o), 64'(!exp_crv || ic_cr_ready_i));
    check_eq("ic_cd_valid", 64'(ic_cd_valid_o), 64'(exp_cdv));
    check_eq("dc_cd_ready", 64'(dc_cd_ready_o), 64'(ic_cd_ready_i && (m_dp != 0)));
    if (exp_cdv) begin
      check_eq("ic_cd_data", ic_cd_data_o, dc_cd_data_i);
      check_eq("ic_cd_last", 64'(ic_cd_last_o), 64'(dc_cd_last_i));
    end
    check_eq("busy", 64'(busy_o),
             64'((m_acq.size() > 0) || (m_os != 0) || (m_cr.size() != 0) || (m_dp != 0)));
    check_eq("cd_err", 64'(cd_err_o), 64'(m_err));
  endtask

  task automatic update_model();
    bit ac_rdy = m_acq.size() < Depth;
    bit dcv    = (m_acq.size() > 0) && (m_os < MaxOs);
    bit crv    = (m_cr.size() == 1);
    bit has    = (m_dp != 0);
    logic [4:0] resp;
    f_ac_in = ic_ac_valid_i && ac_rdy;
    f_dc_ac = dcv && dc_ac_ready_i;
    f_ic_cr = crv && ic_cr_ready_i;
    f_dc_cr = dc_cr_valid_i && (!crv || ic_cr_ready_i);
    f_cd    = dc_cd_valid_i && ic_cd_ready_i && has;
    if (f_dc_ac) begin
      void'(m_acq.pop_front());
      m_os++; dc_pend++; ac_hs_cnt++;
    end
    if (f_ac_in) m_acq.push_back(ac_t'({ic_ac_prot_i, ic_ac_snoop_i, ic_ac_addr_i}));
    if (f_ic_cr) begin
      resp = m_cr.pop_front();
      m_os--;
      if (resp[0]) m_dp++;
    end
    if (f_dc_cr) begin
      m_cr.push_back(dc_cr_resp_i);
      dc_pend--;
      if (dc_cr_resp_i[0]) owed++;
    end
    if (f_cd) begin
      // Beat m_beat of a Bpl-beat line must carry last exactly on the final beat.
      if (dc_cd_last_i != (m_beat == Bpl - 1)) m_err = 1'b1;
      if (dc_cd_last_i) begin
        m_dp--; owed--; m_beat = 0;
      end else begin
        m_beat = (m_beat + 1) % Bpl;
      end
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    #1;
    if (rst_i) reset_model();
    else begin
      check_outputs();
      update_model();
    end
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    ic_ac_valid_i = 0; ic_ac_addr_i = '0; ic_ac_snoop_i = '0; ic_ac_prot_i = '0;
    dc_ac_ready_i = 0; dc_cr_valid_i = 0; dc_cr_resp_i = '0; ic_cr_ready_i = 0;
    dc_cd_valid_i = 0; dc_cd_data_i = '0; dc_cd_last_i = 0; ic_cd_ready_i = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ac_rdy"}, 64'(ic_ac_ready_o), 64'(1));
    check_eq({tag, "_dc_acv"}, 64'(dc_ac_valid_o), 64'(0));
    check_eq({tag, "_ic_crv"}, 64'(ic_cr_valid_o), 64'(0));
    check_eq({tag, "_ic_cdv"}, 64'(ic_cd_valid_o), 64'(0));
    check_eq({tag, "_dc_cdr"}, 64'(dc_cd_ready_o), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy_o), 64'(0));
    check_eq({tag, "_err"}, 64'(cd_err_o), 64'(0));
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_i = 1; tick(); tick();
    rst_i = 0;
  endtask

  task automatic send_ac(input logic [AW-1:0] addr);
    bit done = 0;
    ic_ac_valid_i = 1; ic_ac_addr_i = addr;
    ic_ac_snoop_i = 4'($urandom_range(0, 15)); ic_ac_prot_i = 3'($urandom_range(0, 7));
    for (int i = 0; i < 50 && !done; i++) begin tick(); done = f_ac_in; end
    check_eq("ac_send_done", 64'(done), 64'(1));
  endtask

  task automatic send_cr(input logic [4:0] resp);
    bit done = 0;
    dc_cr_valid_i = 1; dc_cr_resp_i = resp;
    for (int i = 0; i < 50 && !done; i++) begin tick(); done = f_dc_cr; end
    dc_cr_valid_i = 0;
    check_eq("cr_send_done", 64'(done), 64'(1));
  endtask

  task automatic send_cd(input logic [DW-1:0] data, input logic last);
    bit done = 0;
    dc_cd_valid_i = 1; dc_cd_data_i = data; dc_cd_last_i = last;
    for (int i = 0; i < 50 && !done; i++) begin tick(); done = f_cd; end
    dc_cd_valid_i = 0;
    check_eq("cd_send_done", 64'(done), 64'(1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rand_inputs();
    ic_ac_valid_i = ($urandom_range(0, 2) != 0);
    ic_ac_addr_i  = {$urandom, $urandom};
    ic_ac_snoop_i = 4'($urandom_range(0, 15));
    ic_ac_prot_i  = 3'($urandom_range(0, 7));
    dc_ac_ready_i = ($urandom_range(0, 3) != 0);
    dc_cr_valid_i = (dc_pend > 0) && ($urandom_range(0, 1) != 0);
    dc_cr_resp_i  = 5'($urandom_range(0, 31));
    if (owed >= MaxOs) dc_cr_resp_i[0] = 1'b0;
    ic_cr_ready_i = ($urandom_range(0, 3) != 0);
    dc_cd_valid_i = ($urandom_range(0, 2) != 0);
    dc_cd_data_i  = src_data;
    dc_cd_last_i  = (src_beat == Bpl - 1);
    ic_cd_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_i = 1;
    reset_model();
    @(negedge clk_i);
    reset_dut();
    check_reset_state("rst");

    // Queue fills with dcache stalled; fifth request waits for one dequeue.
    reset_dut();
    for (int i = 0; i < 4; i++) send_ac(64'h1000 + 64'(i) * 64);
    ic_ac_addr_i = 64'h1100;
    run(3);
    check_eq("t030_ready_low", 64'(ic_ac_ready_o), 64'(0));
    check_eq("t030_fifth_held", 64'(f_ac_in), 64'(0));
    dc_ac_ready_i = 1; tick(); dc_ac_ready_i = 0;
    check_eq("t030_full_refuse", 64'(f_ac_in), 64'(0));
    tick();
    check_eq("t030_fifth_in", 64'(f_ac_in), 64'(1));
    ic_ac_valid_i = 0;
    run(2);

    // Outstanding limit: four forwarded, fifth released by a single CR.
    reset_dut();
    dc_ac_ready_i = 1;
    for (int i = 0; i < 5; i++) send_ac({$urandom, $urandom});
    ic_ac_valid_i = 0;
    run(8);
    check_eq("t031_hs4", 64'(ac_hs_cnt), 64'(4));
    check_eq("t031_dcv_low", 64'(dc_ac_valid_o), 64'(0));
    ic_cr_ready_i = 1;
    send_cr(5'b00000);
    tick();
    tick();
    check_eq("t031_fifth_fwd", 64'(f_dc_ac), 64'(1));
    check_eq("t031_hs5", 64'(ac_hs_cnt), 64'(5));

    // Data-carrying response followed by a correctly framed two-beat line.
    reset_dut();
    dc_ac_ready_i = 1; ic_cr_ready_i = 1; ic_cd_ready_i = 1;
    send_ac(64'h2000); ic_ac_valid_i = 0;
    run(2);
    send_cr(5'b00001);
    run(2);
    check_eq("t032_busy_hi", 64'(busy_o), 64'(1));
    send_cd(64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
    send_cd(64'h5A5A_5A5A_5A5A_5A5A, 1'b1);
    check_eq("t032_busy_lo", 64'(busy_o), 64'(0));
    check_eq("t032_err_lo", 64'(cd_err_o), 64'(0));
    run(2);

    // last on beat 0 of a two-beat line raises a sticky error.
    reset_dut();
    dc_ac_ready_i = 1; ic_cr_ready_i = 1; ic_cd_ready_i = 1;
    send_ac(64'h3000); ic_ac_valid_i = 0;
    run(2);
    send_cr(5'b00001);
    run(2);
    send_cd(64'h1234_5678_9ABC_DEF0, 1'b1);
    check_eq("t033_err_set", 64'(cd_err_o), 64'(1));
    run(5);
    check_eq("t033_err_sticky", 64'(cd_err_o), 64'(1));

    // Interconnect stalls CR; buffered response holds and nothing is lost.
    reset_dut();
    dc_ac_ready_i = 1;
    send_ac(64'h4000); send_ac(64'h4040); ic_ac_valid_i = 0;
    run(2);
    send_cr(5'b00010);
    dc_cr_valid_i = 1; dc_cr_resp_i = 5'b00100;
    run(10);
    check_eq("t034_resp_hold", 64'(ic_cr_resp_o), 64'(5'b00010));
    check_eq("t034_dcr_low", 64'(dc_cr_ready_o), 64'(0));
    ic_cr_ready_i = 1;
    tick();
    dc_cr_valid_i = 0;
    check_eq("t034_second", 64'(ic_cr_resp_o), 64'(5'b00100));
    tick();
    check_eq("t034_drained", 64'(ic_cr_valid_o), 64'(0));

    // Reset in the middle of a burst with snoops queued.
    reset_dut();
    dc_ac_ready_i = 1; ic_cr_ready_i = 1; ic_cd_ready_i = 1;
    send_ac(64'h5000); ic_ac_valid_i = 0;
    run(2);
    send_cr(5'b00001);
    run(2);
    send_cd(64'hDEAD_BEEF_0000_0001, 1'b0);
    dc_ac_ready_i = 0;
    send_ac(64'h5040); send_ac(64'h5080); ic_ac_valid_i = 0;
    dc_cd_valid_i = 1; dc_cd_last_i = 1;
    rst_i = 1; tick(); rst_i = 0;
    check_reset_state("t035");
    dc_cd_valid_i = 0;
    dc_ac_ready_i = 1;
    send_ac(64'h6000); ic_ac_valid_i = 0;
    tick();
    check_eq("t035_new_fwd", 64'(f_dc_ac), 64'(1));

    // Random traffic against the model.
    reset_dut();
    src_data = {$urandom, $urandom};
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
      if (f_cd) begin
        src_beat = (src_beat + 1) % Bpl;
        src_data = {$urandom, $urandom};
      end
    end
    check_eq("rand_err_clear", 64'(cd_err_o), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ace_snoop_buffer.md
ACE_SNOOP_BUFFER -- requirements
Module: ace_snoop_buffer

Interface
REQ-001 SHALL have parameter AddrWidth, default 64, snoop address width.
REQ-002 SHALL have parameter DataWidth, default 64, CD data width.
REQ-003 SHALL have parameter AcDepth, default 4, AC queue entries (power of two, >=2).
REQ-004 SHALL have parameter MaxOutstanding, default 4, snoops forwarded to the cache but not yet answered on CR (1..15).
REQ-005 SHALL have parameter BeatsPerLine, default 2, CD beats per cache line (>=1).
REQ-006 SHALL have ports: clk_i in 1, sole clock; rst_i in 1, reset, synchronous, active-high.
REQ-007 SHALL have ports: ic_ac_valid_i in 1, ic_ac_ready_o out 1, ic_ac_addr_i in AddrWidth, ic_ac_snoop_i in 4, ic_ac_prot_i in 3, snoop request from the interconnect.
REQ-008 SHALL have ports: dc_ac_valid_o out 1, dc_ac_ready_i in 1, dc_ac_addr_o out AddrWidth, dc_ac_snoop_o out 4, dc_ac_prot_o out 3, snoop request to the dcache snoop port.
REQ-009 SHALL have ports: dc_cr_valid_i in 1, dc_cr_ready_o out 1, dc_cr_resp_i in 5, snoop response from the dcache; ic_cr_valid_o out 1, ic_cr_ready_i in 1, ic_cr_resp_o out 5, snoop response to the interconnect.
REQ-010 SHALL have ports: dc_cd_valid_i in 1, dc_cd_ready_o out 1, dc_cd_data_i in DataWidth, dc_cd_last_i in 1; ic_cd_valid_o out 1, ic_cd_ready_i in 1, ic_cd_data_o out DataWidth, ic_cd_last_o out 1.
REQ-011 SHALL have ports: busy_o out 1, any snoop queued/outstanding/data pending; cd_err_o out 1, sticky CD framing error.

Function
REQ-012 SHALL enqueue an AC request on ic_ac_valid_i & ic_ac_ready_o; ic_ac_ready_o = queue not full, independent of ic_ac_valid_i.
REQ-013 SHALL present the queue head on dc_ac_* with dc_ac_valid_o = queue not empty AND outstanding < MaxOutstanding.
REQ-014 SHALL give minimum latency of 1 cycle from ic AC handshake to dc_ac_valid_o (no combinational AC path).
REQ-015 SHALL hold dc_ac_* stable while dc_ac_valid_o is high and dc_ac_ready_i is low.
REQ-016 SHALL, on simultaneous enqueue and dequeue with a full queue, refuse the enqueue (ready depends only on registered occupancy).
REQ-017 SHALL increment the outstanding counter on dc AC handshake, decrement on ic CR handshake, and leave it unchanged when both occur in one cycle.
REQ-018 SHALL register CR in a 1-entry buffer: dc_cr_ready_o = buffer empty OR ic_cr_ready_i; ic_cr_* driven from the buffer only.
REQ-019 SHALL, on ic CR handshake with ic_cr_resp_o[0] (DataTransfer) = 1, increment the data-pending counter (width clog2(MaxOutstanding+1)).
REQ-020 SHALL pass CD combinationally: ic_cd_valid_o = dc_cd_valid_i AND data_pending != 0; dc_cd_ready_o = ic_cd_ready_i AND data_pending != 0; data and last pass through unchanged.
REQ-021 SHALL run a CD FSM, IDLE -> DATA on first beat handshake with last=0, DATA -> IDLE on last beat handshake; counts beats from 0, wraps to 0 at end of burst.
REQ-022 SHALL decrement data_pending on the handshake of a beat with dc_cd_last_i = 1; simultaneous increment (REQ-019) and decrement leave it unchanged.
REQ-023 SHALL set cd_err_o when last is asserted on a beat index != BeatsPerLine-1, or not asserted on index BeatsPerLine-1; cd_err_o stays set until reset.
REQ-024 SHALL drive busy_o = queue not empty OR outstanding != 0 OR CR buffer full OR data_pending != 0.
REQ-025 SHALL never reorder snoops; CR order equals AC order.

Reset
REQ-026 SHALL, with rst_i high at a clk_i edge, empty queue and CR buffer, clear outstanding, data_pending, beat counter and cd_err_o, and set FSM to IDLE.
REQ-027 SHALL during/after reset drive ic_ac_ready_o=1 (after first edge), dc_ac_valid_o=0, ic_cr_valid_o=0, ic_cd_valid_o=0, dc_cd_ready_o=0, busy_o=0, cd_err_o=0; a reset mid-burst drops all in-flight state without any output handshake.

Structure
REQ-028 SHALL take the AC/CR/CD field widths and snoop/response encodings from the shared ariane_ace package; no local redefinition.
REQ-029 SHALL instantiate fifo_v3 (common_cells) as the AC queue, reset via its synchronous clear driven by rst_i; all other logic local.

Verification
REQ-030 SHALL cover: 5 back-to-back ACs, dc_ac_ready_i=0 -> ic_ac_ready_o low after 4 accepted, 5th held until one dequeue.
REQ-031 SHALL cover: dc_ac_ready_i=1, no CR returned -> exactly 4 dc AC handshakes, dc_ac_valid_o low; one CR with resp 5'b00000 -> 5th forwarded next cycle.
REQ-032 SHALL cover: CR resp 5'b00001 then 2 CD beats 0xA5A5.., 0x5A5A.. last on 2nd -> both forwarded in order, data_pending 1->0, cd_err_o=0, busy_o falls.
REQ-033 SHALL cover: CD beat with last=1 on beat 0 (BeatsPerLine=2) -> cd_err_o=1 and stays 1.
REQ-034 SHALL cover: ic_cr_ready_i=0 for 10 cycles -> ic_cr_resp_o stable, dc_cr_ready_o=0 after first CR, no CR lost.
REQ-035 SHALL cover: rst_i asserted mid-CD burst with 2 snoops queued -> next cycle all valids 0, busy_o=0, new AC accepted normally.
